// File: rtl/seq_alu.sv
// Multi-cycle 8-bit ALU between the register file outputs and its write-back port.
// Optional OVERFLOW output is enabled by defining SEQ_ALU_OVERFLOW_EN.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [2:0]       select_i,
    input  logic             start_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             done_o
`ifdef SEQ_ALU_OVERFLOW_EN
    ,
    output logic             overflow_o
`endif
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef SEQ_ALU_OVERFLOW_EN
    localparam int AW = 2 * WIDTH;
`else
    localparam int AW = WIDTH;
`endif

    localparam logic [2:0] OP_FWD  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_MULT = 3'b100;
    localparam logic [2:0] OP_SLL  = 3'b101;
    localparam logic [2:0] OP_SRL  = 3'b110;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state_q;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] mplier_q;
    logic [AW-1:0]    mcand_q;
    logic [AW-1:0]    acc_q;
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;

    logic [SW-1:0]    amt;
    logic [WIDTH-1:0] single_d;
    logic [WIDTH-1:0] shift_d;
    logic [AW-1:0]    acc_d;
    logic             iter_start;

    always_comb begin
        amt = data2_i[SW-1:0];
        case (select_i)
            OP_FWD:  single_d = data2_i;
            OP_ADD:  single_d = data1_i + data2_i;
            OP_AND:  single_d = data1_i & data2_i;
            OP_OR:   single_d = data1_i | data2_i;
            default: single_d = data1_i;  // shift by zero passes DATA1 through
        endcase
        iter_start = select_i[2] && ((select_i == OP_MULT) || (amt != '0));

        case (op_q)
            OP_SLL:  shift_d = work_q << 1;
            OP_SRL:  shift_d = work_q >> 1;
            default: shift_d = {work_q[0], work_q[WIDTH-1:1]};
        endcase
        acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

`ifdef SEQ_ALU_OVERFLOW_EN
    logic             ovf_q;
    logic [WIDTH-1:0] sum;
    logic             add_ovf;

    always_comb begin
        sum     = data1_i + data2_i;
        add_ovf = (select_i == OP_ADD) &&
                  (data1_i[WIDTH-1] == data2_i[WIDTH-1]) &&
                  (sum[WIDTH-1] != data1_i[WIDTH-1]);
    end

    assign overflow_o = ovf_q;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            op_q     <= OP_FWD;
            cnt_q    <= '0;
            work_q   <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQ_ALU_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        op_q     <= select_i;
                        work_q   <= data1_i;
                        mplier_q <= data2_i;
                        mcand_q  <= AW'(data1_i);
                        acc_q    <= '0;
                        if (iter_start) begin
                            state_q <= EXEC;
                            busy_q  <= 1'b1;
                            cnt_q   <= (select_i == OP_MULT) ? CW'(WIDTH) : CW'(amt);
                        end else begin
                            result_q <= single_d;
                            done_q   <= 1'b1;
`ifdef SEQ_ALU_OVERFLOW_EN
                            ovf_q    <= add_ovf;
`endif
                        end
                    end
                end
                EXEC: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (op_q == OP_MULT) begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                    end else begin
                        work_q <= shift_d;
                    end
                    if (cnt_q == CW'(1)) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= (op_q == OP_MULT) ? acc_d[WIDTH-1:0] : shift_d;
`ifdef SEQ_ALU_OVERFLOW_EN
                        ovf_q    <= (op_q == OP_MULT) && (|acc_d[AW-1:WIDTH]);
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result_o = result_q;
    assign zero_o   = (result_q == '0);
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expected results queued at issue, compared on DONE.
module tb_seq_alu;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [2:0] sel;
    logic [7:0] result;
    logic       zero;
    logic       busy;
    logic       done;
    logic       ovf;

    typedef struct packed {
        logic [7:0] res;
        logic       ovf;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] hold_exp = 8'h00;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .data1_i    (d1),
        .data2_i    (d2),
        .select_i   (sel),
        .start_i    (start),
        .result_o   (result),
        .zero_o     (zero),
        .busy_o     (busy),
        .done_o     (done)
`ifdef SEQ_ALU_OVERFLOW_EN
        ,
        .overflow_o (ovf)
`endif
    );
`ifndef SEQ_ALU_OVERFLOW_EN
    assign ovf = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        logic [7:0]  r;
        logic [2:0]  n;
        logic        o;
        n = b[2:0];
        p = {8'h00, a} * {8'h00, b};
        o = 1'b0;
        case (op)
            3'd0: r = b;
            3'd1: begin
                r = a + b;
                o = (a[7] == b[7]) && (r[7] != a[7]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: begin
                r = p[7:0];
                o = (p[15:8] != 8'h00);
            end
            3'd5: r = a << n;
            3'd6: r = a >> n;
            default: r = (a >> n) | (a << (4'd8 - {1'b0, n}));
        endcase
        return '{res: r, ovf: o};
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [7:0] b);
        if (op < 3'd4)  return 0;
        if (op == 3'd4) return 8;
        return int'(b[2:0]);
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("result", result, mon_e.res);
                check("zero", zero, mon_e.res == 8'h00);
`ifdef SEQ_ALU_OVERFLOW_EN
                check("overflow", ovf, mon_e.ovf);
`endif
                hold_exp = mon_e.res;
            end
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input bit disturb);
        int cyc;
        bit seen;
        @(negedge clk);
        sel = op; d1 = a; d2 = b; start = 1'b1;
        sb.push_back(model(op, a, b));
        @(posedge clk);
        #1 start = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                check("busy", busy, 1'b1);
                check("hold", result, hold_exp);
                if (disturb && cyc == 2) begin
                    start = 1'b1; sel = 3'b001;
                    d1 = 8'($urandom); d2 = 8'($urandom);
                end
                if (disturb && cyc == 3) start = 1'b0;
                cyc++;
            end
        end
        check("done_seen", seen, 1'b1);
        check("latency", cyc, latency(op, b));
        check("busy_at_done", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; sel = 3'd0; d1 = 8'h00; d2 = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_result", result, 8'h00);
        check("rst_zero", zero, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        reset = 1'b0;

        run_op(3'd1, 8'h7F, 8'h01, 1'b0);
        @(negedge clk);
        check("done_pulse", done, 1'b0);
        check("add_zero", zero, 1'b0);

        run_op(3'd4, 8'h0D, 8'h0B, 1'b0);
        run_op(3'd4, 8'h10, 8'h10, 1'b0);
        run_op(3'd5, 8'h81, 8'h03, 1'b0);
        run_op(3'd7, 8'h81, 8'h01, 1'b0);
        run_op(3'd6, 8'h81, 8'h00, 1'b0);
        run_op(3'd4, 8'h0D, 8'h0B, 1'b1);

        // reset lands on E4 of a multiply; its queued result is withdrawn
        @(negedge clk);
        sel = 3'd4; d1 = 8'h0D; d2 = 8'h0B; start = 1'b1;
        sb.push_back(model(3'd4, 8'h0D, 8'h0B));
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        check("mid_rst_result", result, 8'h00);
        check("mid_rst_zero", zero, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        hold_exp = 8'h00;
        reset = 1'b0; sel = 3'd0; d1 = 8'hAA; d2 = 8'h55; start = 1'b1;
        sb.push_back(model(3'd0, 8'hAA, 8'h55));
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("fwd_done", done, 1'b1);
        check("fwd_result", result, 8'h55);

        // back-to-back single-cycle ops
        @(negedge clk);
        sel = 3'd1; d1 = 8'h12; d2 = 8'h34; start = 1'b1;
        sb.push_back(model(3'd1, 8'h12, 8'h34));
        @(posedge clk);
        @(negedge clk);
        check("b2b_done0", done, 1'b1);
        sel = 3'd3; d1 = 8'hF0; d2 = 8'h0F; start = 1'b1;
        sb.push_back(model(3'd3, 8'hF0, 8'h0F));
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("b2b_done1", done, 1'b1);
        check("b2b_result", result, 8'hFF);
        @(negedge clk);
        check("b2b_done_end", done, 1'b0);

        for (int i = 0; i < 12; i++) begin
            run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b0);
        end

        repeat (12) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
